bomb_game_ctrl: RTL and testbench

Game sequencer for the bomb-dismantlement display. Arms the bomb on a start request, burns the fuse one step per fixed tick interval, and watches the wire-cut switches for the correct wire. It then drives the fuse level, display enable and fail/win indications consumed by the dot-matrix display driver. It replaces free-running fuse counting with a single authoritative game state machine.

---
 rtl/bomb_game_pkg.sv | 15 +
 rtl/bomb_edge_det.sv | 30 +++
 rtl/bomb_game_ctrl.sv | 158 +++++++++++++++
 tb/tb_bomb_game_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_game_pkg.sv
// Shared constants for the bomb game sequencer: state encoding, state width
// and the default number of fuse steps.
package bomb_game_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] ST_ARMED    = 2'd1;
  localparam logic [ST_W-1:0] ST_DEFUSED  = 2'd2;
  localparam logic [ST_W-1:0] ST_EXPLODED = 2'd3;

  localparam int FUSE_STEPS_DEF = 4;
  localparam int FUSE_W         = 3;

endpackage

// File: rtl/bomb_edge_det.sv
// Input register plus rising-edge detector. The raw input is sampled once;
// an edge is a registered 1 whose previous registered sample was 0.
module bomb_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_q;
  logic [W-1:0] r_prev;

  // Capture the raw input and keep the previous registered sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q    <= '0;
      r_prev <= '0;
    end else begin
      r_q    <= i_d;
      r_prev <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_prev;

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb game sequencer: arms on a start edge, burns one fuse step every
// TICKS_PER_STEP cycles and resolves wire cuts into DEFUSED or EXPLODED.
// Optional feature macro: BOMB_PENALTY_EN (a wrong cut costs one fuse step
// instead of exploding at once).
module bomb_game_ctrl
  import bomb_game_pkg::*;
#(
  parameter int TICKS_PER_STEP = 100,
  parameter int NUM_WIRES      = 4,
  parameter int CORRECT_WIRE   = 2,
  parameter int FUSE_STEPS     = FUSE_STEPS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_WIRES-1:0] cut_sw,
  output logic [2:0]           fuse_level,
  output logic                 bomb_en,
  output logic [NUM_WIRES-1:0] cut_mask,
  output logic                 fail,
  output logic                 win,
  output logic [1:0]           state
);

  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICKS_PER_STEP - 1);
  localparam logic [CNT_W-1:0]     TICK_ONE  = CNT_W'(1);
  localparam logic [FUSE_W-1:0]    FUSE_MAX  = FUSE_W'(FUSE_STEPS);
  localparam logic [NUM_WIRES-1:0] GOOD_MASK =
    {{(NUM_WIRES-1){1'b0}}, 1'b1} << CORRECT_WIRE;

  logic                 w_start_q;
  logic                 w_start_rise;
  logic [NUM_WIRES-1:0] w_cut_q;
  logic [NUM_WIRES-1:0] w_cut_rise;

  logic [ST_W-1:0]      r_state;
  logic [FUSE_W-1:0]    r_fuse;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_WIRES-1:0] r_mask;
  logic                 r_bomb_en;
  logic                 r_fail;
  logic                 r_win;

  logic [ST_W-1:0]      w_state_nxt;
  logic [FUSE_W-1:0]    w_fuse_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [NUM_WIRES-1:0] w_mask_nxt;
  logic [FUSE_W-1:0]    w_fuse_inc;
  logic                 w_wrong;
  logic                 w_right;
  logic                 w_expire;
  logic                 w_arm_req;

  bomb_edge_det #(.W(1)) u_start_det (
    .clk    (clk),
    .rst    (rst),
    .i_d    (start),
    .o_q    (w_start_q),
    .o_rise (w_start_rise)
  );

  bomb_edge_det #(.W(NUM_WIRES)) u_cut_det (
    .clk    (clk),
    .rst    (rst),
    .i_d    (cut_sw),
    .o_q    (w_cut_q),
    .o_rise (w_cut_rise)
  );

  assign w_wrong    = |(w_cut_rise & ~GOOD_MASK);
  assign w_right    = |(w_cut_rise & GOOD_MASK);
  assign w_expire   = (r_cnt == TICK_LAST);
  assign w_fuse_inc = r_fuse + 3'd1;
  // Arming needs a fresh start edge with every registered switch still low.
  assign w_arm_req  = w_start_q & w_start_rise & ~(|w_cut_q);

  // Next-state logic: wrong cut beats correct cut, correct cut beats expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_fuse_nxt  = r_fuse;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    case (r_state)
      ST_ARMED: begin
        w_mask_nxt = r_mask | w_cut_rise;
        if (w_wrong) begin
`ifdef BOMB_PENALTY_EN
          // A coincident expiry is absorbed: only this single step is burnt.
          w_fuse_nxt = w_fuse_inc;
          w_cnt_nxt  = '0;
          if (w_fuse_inc == FUSE_MAX) begin
            w_state_nxt = ST_EXPLODED;
          end else begin
            w_state_nxt = ST_ARMED;
          end
`else
          w_state_nxt = ST_EXPLODED;
`endif
        end else if (w_right) begin
          w_state_nxt = ST_DEFUSED;
        end else if (w_expire) begin
          w_cnt_nxt  = '0;
          w_fuse_nxt = w_fuse_inc;
          if (w_fuse_inc == FUSE_MAX) begin
            w_state_nxt = ST_EXPLODED;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end else begin
          w_cnt_nxt = r_cnt + TICK_ONE;
        end
      end
      ST_IDLE, ST_DEFUSED, ST_EXPLODED: begin
        if (w_arm_req) begin
          w_state_nxt = ST_ARMED;
          w_fuse_nxt  = '0;
          w_cnt_nxt   = '0;
          w_mask_nxt  = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered indications derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_fuse    <= '0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_bomb_en <= 1'b0;
      r_fail    <= 1'b0;
      r_win     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fuse    <= w_fuse_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mask    <= w_mask_nxt;
      r_bomb_en <= (w_state_nxt != ST_IDLE);
      r_fail    <= (w_state_nxt == ST_EXPLODED);
      r_win     <= (w_state_nxt == ST_DEFUSED);
    end
  end

  assign state      = r_state;
  assign fuse_level = r_fuse;
  assign cut_mask   = r_mask;
  assign bomb_en    = r_bomb_en;
  assign fail       = r_fail;
  assign win        = r_win;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Self-checking bench for bomb_game_ctrl: directed game scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a game-level reference model.
module tb_bomb_game_ctrl;

  localparam int T  = 4;
  localparam int NW = 4;
  localparam int CW = 2;
  localparam int FS = 4;

  localparam int S_IDLE = 0;
  localparam int S_ARM  = 1;
  localparam int S_DEF  = 2;
  localparam int S_EXP  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] cut_sw;
  logic [2:0]    fuse_level;
  logic          bomb_en;
  logic [NW-1:0] cut_mask;
  logic          fail;
  logic          win;
  logic [1:0]    state;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model of the game as seen through the outputs.
  int          m_state = 0;
  int          m_fuse  = 0;
  int          m_ticks = 0;
  logic [3:0]  m_mask  = 4'd0;
  logic        m_sq = 1'b0, m_sp = 1'b0;
  logic [3:0]  m_cq = 4'd0, m_cp = 4'd0;

  bomb_game_ctrl #(
    .TICKS_PER_STEP (T),
    .NUM_WIRES      (NW),
    .CORRECT_WIRE   (CW),
    .FUSE_STEPS     (FS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cut_sw     (cut_sw),
    .fuse_level (fuse_level),
    .bomb_en    (bomb_en),
    .cut_mask   (cut_mask),
    .fail       (fail),
    .win        (win),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Game rules applied once per clock from the inputs seen one edge earlier.
  always @(posedge clk) begin : model
    int         ns, nf, nt;
    logic [3:0] nm, c_e;
    logic       s_e, wrong, right;
    ns = m_state; nf = m_fuse; nt = m_ticks; nm = m_mask;
    if (!rst) begin
      m_state <= S_IDLE; m_fuse <= 0; m_ticks <= 0; m_mask <= 4'd0;
      m_sq <= 1'b0; m_sp <= 1'b0; m_cq <= 4'd0; m_cp <= 4'd0;
    end else begin
      s_e   = m_sq & ~m_sp;
      c_e   = m_cq & ~m_cp;
      right = c_e[CW];
      wrong = ((c_e & ~(4'd1 << CW)) != 4'd0);
      if (m_state == S_ARM) begin
        nm = m_mask | c_e;
        if (wrong) begin
`ifdef BOMB_PENALTY_EN
          nf = m_fuse + 1;
          nt = 0;
          if (nf == FS) ns = S_EXP;
`else
          ns = S_EXP;
`endif
        end else if (right) begin
          ns = S_DEF;
        end else if (m_ticks == T - 1) begin
          nt = 0;
          nf = m_fuse + 1;
          if (nf == FS) ns = S_EXP;
        end else begin
          nt = m_ticks + 1;
        end
      end else if (s_e && m_cq == 4'd0) begin
        ns = S_ARM; nf = 0; nt = 0; nm = 4'd0;
      end
      m_state <= ns; m_fuse <= nf; m_ticks <= nt; m_mask <= nm;
      m_sp <= m_sq; m_sq <= start; m_cp <= m_cq; m_cq <= cut_sw;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",    8'(state),      8'(m_state));
      chk("fuse",     8'(fuse_level), 8'(m_fuse));
      chk("mask",     8'(cut_mask),   8'(m_mask));
      chk("bomb_en",  8'(bomb_en),    8'(m_state != S_IDLE));
      chk("fail",     8'(fail),       8'(m_state == S_EXP));
      chk("win",      8'(win),        8'(m_state == S_DEF));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc = cyc + n;
  endtask

  task automatic at(input int c);
    step(c - cyc);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; cut_sw = 4'd0;
    step(2);
    rst = 1'b1;
    step(2);
  endtask

  // Start pulse; returns just after the ARMED entry edge (cycle 0).
  task automatic arm();
    start = 1'b1;
    step(2);
    start = 1'b0;
    cyc = 0;
  endtask

  // Literal expectations on DUT and model at the current cycle.
  task automatic lit(input string nm, input int s, input int f, input int mk);
    chk({nm, "_state"}, 8'(state), 8'(s));
    chk({nm, "_fuse"},  8'(fuse_level), 8'(f));
    chk({nm, "_mask"},  8'(cut_mask), 8'(mk));
    chk({nm, "_en"},    8'(bomb_en), 8'(s != S_IDLE));
    chk({nm, "_fail"},  8'(fail), 8'(s == S_EXP));
    chk({nm, "_win"},   8'(win), 8'(s == S_DEF));
    chk({nm, "_mstate"}, 8'(m_state), 8'(s));
    chk({nm, "_mfuse"},  8'(m_fuse), 8'(f));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cut_sw = 4'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(1);
    lit("reset", S_IDLE, 0, 0);

    // Uncut countdown.
    do_reset(); arm();
    lit("arm0", S_ARM, 0, 0);
    at(3);  lit("c3", S_ARM, 0, 0);
    at(4);  lit("c4", S_ARM, 1, 0);
    at(8);  lit("c8", S_ARM, 2, 0);
    at(12); lit("c12", S_ARM, 3, 0);
    at(15); lit("c15", S_ARM, 3, 0);
    at(16); lit("c16", S_EXP, 4, 0);
    at(24); lit("c24", S_EXP, 4, 0);

    // Defuse on the correct wire.
    do_reset(); arm();
    at(6);  cut_sw = 4'b0100;
    at(7);  lit("def7", S_ARM, 1, 0);
    at(8);  lit("def8", S_DEF, 1, 4);
    at(40); lit("def40", S_DEF, 1, 4);

    // Wrong cut.
    do_reset(); arm();
    at(1); cut_sw = 4'b0001;
`ifdef BOMB_PENALTY_EN
    at(3); lit("wr3", S_ARM, 1, 1);
    at(6); lit("wr6", S_ARM, 1, 1);
    at(7); lit("wr7", S_ARM, 2, 1);
`else
    at(3); lit("wr3", S_EXP, 0, 1);
    at(9); lit("wr9", S_EXP, 0, 1);
`endif

    // Wrong and correct wire cut together.
    do_reset(); arm();
    at(1); cut_sw = 4'b0101;
`ifdef BOMB_PENALTY_EN
    at(3); lit("sim3", S_ARM, 1, 5);
`else
    at(3); lit("sim3", S_EXP, 0, 5);
`endif

    // Reset mid-countdown, then a start with a switch high.
    do_reset(); arm();
    at(9); lit("rm9", S_ARM, 2, 0);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    lit("rm10", S_IDLE, 0, 0);
    cut_sw = 4'b0001;
    step(2);
    start = 1'b1;
    step(6);
    lit("rmblk", S_IDLE, 0, 0);
    start = 1'b0;

    // Correct cut landing on the expiry cycle.
    do_reset(); arm();
    at(14); cut_sw = 4'b0100;
    at(15); lit("ex15", S_ARM, 3, 0);
    at(16); lit("ex16", S_DEF, 3, 4);

    // Randomized play against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) start = ~start;
      for (int b = 0; b < NW; b++) begin
        if ($urandom_range(0, 24) == 0) cut_sw[b] = ~cut_sw[b];
      end
      if ($urandom_range(0, 29) == 0) cut_sw = 4'd0;
      step(1);
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
